// File: rtl/pic_pkg.sv
// pic_pkg: shared phase encoding, opcode classes and skip/branch match patterns for the PIC-style core
package pic_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } phase_e;

    localparam logic [1:0] CLS_BYTE   = 2'b00;
    localparam logic [1:0] CLS_BIT    = 2'b01;
    localparam logic [1:0] CLS_BRANCH = 2'b10;
    localparam logic [1:0] CLS_LIT    = 2'b11;

    localparam logic [5:0] PAT_DECFSZ = 6'b001011;
    localparam logic [5:0] PAT_INCFSZ = 6'b001111;
    localparam logic [3:0] PAT_BTFSC  = 4'b0110;
    localparam logic [3:0] PAT_BTFSS  = 4'b0111;
    localparam logic [2:0] PAT_GOTO   = 3'b100;
    localparam logic [3:0] PAT_CALL   = 4'b1010;
    localparam logic [7:0] PAT_RETURN = 8'hB0;

    // Skip-next decision for the test-and-skip instructions given the ALU zero flag
    function automatic logic skip_hit(input logic [7:0] op, input logic zero);
        return ((op[7:2] == PAT_DECFSZ || op[7:2] == PAT_INCFSZ || op[7:4] == PAT_BTFSC) && zero) ||
               (op[7:4] == PAT_BTFSS && !zero);
    endfunction

endpackage

// File: rtl/pic_call_stack.sv
// pic_call_stack: circular LIFO of return addresses; overflow overwrites the oldest entry
module pic_call_stack
    import pic_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top
);

    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0]  mem_q [STACK_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;

    // Pointer arithmetic wraps modulo the depth so pops from empty read the last wrapped slot
    always_comb begin
        ptr_inc = (ptr_q == PTR_W'(STACK_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        ptr_dec = (ptr_q == '0) ? PTR_W'(STACK_DEPTH - 1) : ptr_q - PTR_W'(1);
        ptr_d   = push ? ptr_inc : pop ? ptr_dec : ptr_q;
        top     = mem_q[ptr_dec];
    end

    // Store pushed address at the pointer and advance or retreat the pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (push) mem_q[ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pic_cycle_sequencer.sv
// pic_cycle_sequencer: FETCH/DECODE/EXEC/WB controller with skip and branch resolution (optional return stack via PIC_CALL_STACK_EN)
module pic_cycle_sequencer
    import pic_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            halt_i,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    output logic [7:0]      ir,
    input  logic            d_i,
    input  logic            alu_zero,
    output logic            alu_en,
    output logic            w_we,
    output logic            f_we,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      phase
);

    phase_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc, ret_pc;
    logic [7:0]      ir_q, ir_d;
    logic            skip_q, skip_d, zero_q, zero_d;
    logic            alu_en_q, alu_en_d, w_we_q, w_we_d, f_we_q, f_we_d;
    logic            wr_w, wr_f, has_dst;

`ifdef PIC_CALL_STACK_EN
    logic            push, pop;
    logic [PC_W-1:0] top;

    assign push   = state_q == WB && !skip_q && ir_q[7:4] == PAT_CALL;
    assign pop    = state_q == WB && !skip_q && ir_q == PAT_RETURN;
    assign ret_pc = top;

    pic_call_stack #(.PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (top)
    );
`else
    logic unused_depth;

    assign unused_depth = ^STACK_DEPTH;
    assign ret_pc       = pc_inc;
`endif

    assign imem_req  = rst_n && state_q == FETCH && !halt_i;
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign pc        = pc_q;
    assign phase     = state_q;
    assign alu_en    = alu_en_q;
    assign w_we      = w_we_q;
    assign f_we      = f_we_q;

    // Next-state, next-PC and next-strobe logic; strobes are staged one phase ahead so they register into place
    always_comb begin
        pc_inc   = pc_q + PC_W'(1);
        has_dst  = ir_q[7:6] == CLS_BYTE && ir_q[5:1] != 5'd0;
        wr_w     = ir_q[7:6] == CLS_LIT || (has_dst && !d_i);
        wr_f     = (has_dst && d_i) || (ir_q[7:6] == CLS_BIT && !ir_q[5]);
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        skip_d   = skip_q;
        zero_d   = zero_q;
        alu_en_d = 1'b0;
        w_we_d   = 1'b0;
        f_we_d   = 1'b0;
        case (state_q)
            FETCH: begin
                if (!halt_i && imem_ack) begin
                    ir_d    = imem_data;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alu_en_d = !skip_q;
                state_d  = EXEC;
            end
            EXEC: begin
                zero_d  = alu_zero;
                w_we_d  = !skip_q && wr_w;
                f_we_d  = !skip_q && wr_f;
                state_d = WB;
            end
            WB: begin
                pc_d    = skip_q                    ? pc_inc :
                          ir_q[7:5] == PAT_GOTO     ? PC_W'(ir_q[4:0]) :
                          ir_q[7:4] == PAT_CALL     ? PC_W'(ir_q[3:0]) :
                          ir_q == PAT_RETURN        ? ret_pc : pc_inc;
                skip_d  = !skip_q && skip_hit(ir_q, zero_q);
                state_d = FETCH;
            end
        endcase
    end

    // Sequencer state and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= '0;
            ir_q     <= 8'h00;
            skip_q   <= 1'b0;
            zero_q   <= 1'b0;
            alu_en_q <= 1'b0;
            w_we_q   <= 1'b0;
            f_we_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            skip_q   <= skip_d;
            zero_q   <= zero_d;
            alu_en_q <= alu_en_d;
            w_we_q   <= w_we_d;
            f_we_q   <= f_we_d;
        end
    end

endmodule

// File: tb/tb_pic_cycle_sequencer.sv
// tb_pic_cycle_sequencer: directed and randomized instruction stream checked against an opcode-level reference model
module tb_pic_cycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       halt_i = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic [7:0] ir;
    logic       d_i = 1'b0;
    logic       alu_zero = 1'b0;
    logic       alu_en, w_we, f_we;
    logic [7:0] pc;
    logic [1:0] phase;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int m_pc   = 0;
    bit m_skip = 0;
    int m_ir   = 0;
    int stk [4];
    int sp     = 0;

    pic_cycle_sequencer #(.PC_W(8), .STACK_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .halt_i    (halt_i),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .ir        (ir),
        .d_i       (d_i),
        .alu_zero  (alu_zero),
        .alu_en    (alu_en),
        .w_we      (w_we),
        .f_we      (f_we),
        .pc        (pc),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_pc   = 0;
        m_skip = 0;
        m_ir   = 0;
        sp     = 0;
        for (int i = 0; i < 4; i++) stk[i] = 0;
    endtask

    // One full instruction: lat wait cycles in FETCH, then DECODE/EXEC/WB, checked against the model
    task automatic run_instr(input logic [7:0] op, input int lat, input logic d, input logic z);
        bit an, ew, ef, ns;
        int np;
        an = m_skip;
        ew = !an && (op[7:6] == 2'b11 || (op[7:6] == 2'b00 && op[5:1] != 0 && !d));
        ef = !an && ((op[7:6] == 2'b00 && op[5:1] != 0 && d) || (op[7:6] == 2'b01 && !op[5]));
        ns = !an && ((((op[7:2] == 6'b001011) || (op[7:2] == 6'b001111) || (op[7:4] == 4'b0110)) && z) ||
                     (op[7:4] == 4'b0111 && !z));
        np = (m_pc + 1) % 256;
        if (!an) begin
            if (op[7:5] == 3'b100) np = op[4:0];
            else if (op[7:4] == 4'b1010) begin
`ifdef PIC_CALL_STACK_EN
                stk[sp] = (m_pc + 1) % 256;
                sp = (sp + 1) % 4;
`endif
                np = op[3:0];
            end else if (op == 8'hB0) begin
`ifdef PIC_CALL_STACK_EN
                sp = (sp + 3) % 4;
                np = stk[sp];
`endif
            end
        end
        for (int i = 0; i < lat; i++) begin
            imem_ack = 1'b0;
            #1;
            chk("wait_req", imem_req, 1);
            chk("wait_phase", phase, 0);
            tick;
        end
        imem_ack  = 1'b1;
        imem_data = op;
        #1;
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, m_pc);
        chk("fetch_phase", phase, 0);
        tick;
        imem_ack = 1'b0;
        d_i      = d;
        alu_zero = z;
        #1;
        chk("dec_phase", phase, 1);
        chk("dec_ir", ir, op);
        chk("dec_req", imem_req, 0);
        chk("dec_strobes", {alu_en, w_we, f_we}, 0);
        tick;
        chk("exec_phase", phase, 2);
        chk("exec_alu_en", alu_en, !an);
        chk("exec_we", {w_we, f_we}, 0);
        tick;
        chk("wb_phase", phase, 3);
        chk("wb_alu_en", alu_en, 0);
        chk("wb_w_we", w_we, ew);
        chk("wb_f_we", f_we, ef);
        tick;
        m_pc   = np;
        m_skip = ns;
        m_ir   = op;
        chk("next_pc", pc, m_pc);
        chk("next_phase", phase, 0);
        chk("next_strobes", {alu_en, w_we, f_we}, 0);
    endtask

    initial begin
        model_reset;
        tick;
        chk("rst_req", imem_req, 0);
        chk("rst_pc", pc, 0);
        tick;
        rst_n = 1'b1;
        #1;
        chk("rst_phase", phase, 0);
        chk("rst_ir", ir, 8'h00);
        chk("rst_strobes", {alu_en, w_we, f_we}, 0);
        chk("rst_req_up", imem_req, 1);

        run_instr(8'hC5, 0, 1'b0, 1'b0);
        run_instr(8'h1E, 0, 1'b1, 1'b0);
        run_instr(8'h1C, 0, 1'b0, 1'b0);
        run_instr(8'h2E, 0, 1'b0, 1'b1);
        run_instr(8'hC1, 0, 1'b0, 1'b0);
        run_instr(8'h83, 0, 1'b0, 1'b0);
        run_instr(8'h9F, 0, 1'b0, 1'b0);
        chk("goto_pc", pc, 8'h1F);
        while (m_pc != 8'hFF) run_instr(8'h00, 0, 1'b0, 1'b0);
        run_instr(8'hC0, 0, 1'b0, 1'b0);
        chk("wrap_pc", pc, 8'h00);

        run_instr(8'h82, 0, 1'b0, 1'b0);
        run_instr(8'hA7, 0, 1'b0, 1'b0);
        chk("call_pc", pc, 8'h07);
        run_instr(8'hB0, 0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) run_instr(8'hA0 | 8'(i), 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) run_instr(8'hB0, 0, 1'b0, 1'b0);

        halt_i    = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 8'hC9;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("halt_req", imem_req, 0);
            chk("halt_phase", phase, 0);
            tick;
        end
        chk("halt_ir", ir, m_ir);
        chk("halt_pc", pc, m_pc);
        halt_i   = 1'b0;
        imem_ack = 1'b0;

        run_instr(8'hC3, 3, 1'b0, 1'b0);

        #1;
        chk("mid_req", imem_req, 1);
        tick;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_phase", phase, 0);
        imem_ack  = 1'b1;
        imem_data = 8'hC7;
        tick;
        chk("late_ack_ir", ir, 8'h00);
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        model_reset;
        #1;
        chk("post_rst_req", imem_req, 1);
        chk("post_rst_phase", phase, 0);

        for (int n = 0; n < 150; n++)
            run_instr(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
